led_scan_timer: RTL and testbench
=================================

// Module: led_scan_timer
// PURPOSE
//  Timing stage directly downstream of the on-chip oscillator (OSCH). It runs on the
//  oscillator output and derives all LED-array timing from it:
//   - a prescaled PWM tick and PWM phase counter;
//   - row scan with a blanking gap between rows, plus a frame strobe;
//   - the standby handshake that drives the oscillator's STDBY pin.
//  The row drivers and PWM comparators consume its outputs.
// PARAMETERS
//  ROWS       8    number of scanned rows (>=2); ROW_W = $clog2(ROWS), a localparam
//  PWM_BITS   4    width of the PWM phase; one row lasts 2**PWM_BITS pwm_ticks
//  PRESC_W    12   width of the prescaler and of presc_val
//  PRESC_DEF  16   prescale divisor after reset; clk cycles per pwm_tick (>=2)
//  BLANK_CYC  4    clk cycles of blanking between rows (>=1)
// PORTS
//  clk           in   1         oscillator clock (OSCH OSC output)
//  rst_n         in   1         asynchronous active-low reset
//  en            in   1         1 = scanning allowed; 0 = hold and blank
//  presc_load    in   1         1-cycle strobe that loads presc_val as the new divisor
//  presc_val     in   PRESC_W   new divisor; values <2 are clamped to 2
//  stdby_req     in   1         request to stop the oscillator
//  stdby_ok      out  1         drives OSCH STDBY; 1 = oscillator may stop
//  row_idx       out  ROW_W     current row index
//  row_sel       out  ROWS      one-hot row enable; all zero while blank
//  pwm_phase     out  PWM_BITS  PWM phase within the current row
//  pwm_tick      out  1         1-cycle pulse each time pwm_phase advances
//  blank         out  1         1 = rows off (blanking, disabled or sleeping)
//  frame_strobe  out  1         1-cycle pulse when row_idx wraps ROWS-1 -> 0
// BEHAVIOUR
//  Reset values:
//   - state=BLANK, blank=1, row_sel=0, row_idx=0, pwm_phase=0;
//   - pwm_tick=0, frame_strobe=0, stdby_ok=0;
//   - divisor=PRESC_DEF, prescaler count=0, blank count=0.
//  All outputs are registered, except stdby_ok and row_sel (see below).
//  FSM states: BLANK, SCAN, SLEEP.
//  BLANK:
//   - blank count runs 0..BLANK_CYC-1; after the last cycle -> SCAN;
//   - the prescaler and pwm_phase hold.
//  SCAN:
//   - blank=0, row_sel = 1<<row_idx (combinational from the registered state);
//   - prescaler counts 0..divisor-1; at the terminal count it goes to 0, pwm_tick=1
//     for one cycle, and pwm_phase increments;
//   - row end is the tick where pwm_phase wraps 2**PWM_BITS-1 -> 0;
//   - at row end, on the same edge: row_idx increments (ROWS-1 wraps to 0, with
//     frame_strobe=1 that cycle) and the state -> BLANK, or -> SLEEP if stdby_req=1.
//  SLEEP:
//   - blank=1, counters hold;
//   - stdby_ok = (state==SLEEP) & stdby_req, combinational, so dropping stdby_req
//     releases STDBY even while clk is stopped;
//   - stdby_req=0 -> BLANK; the already-advanced row_idx is kept.
//  Standby is honoured only at a row boundary; a row is never cut short.
//  The exception is en=0: then stdby_req takes effect on the next edge.
//  en=0 (any state except SLEEP):
//   - next state is BLANK with blank count held at 0;
//   - prescaler, pwm_phase and row_idx hold; pwm_tick=0;
//   - on en=1, a full BLANK_CYC blank precedes scanning.
//  presc_load:
//   - the value is captured into a pending register;
//   - it becomes the active divisor at the next prescaler terminal count, or
//     immediately if state!=SCAN;
//   - a second load before that point overwrites the pending value.
//  Simultaneous row end and frame wrap: both pulses and the transition occur on the
//  same edge. stdby_req deasserted during BLANK or SCAN has no effect.
//  Reset asserted mid-row: all state returns to the reset values asynchronously.
// TESTING
//  T1 reset: rst_n=0 -> blank=1, row_sel=0, stdby_ok=0; release -> row_sel=8'h01
//     after 4 clk.
//  T2 tick spacing with PRESC_DEF=16: pwm_tick every 16 clk; pwm_phase 0..15;
//     16 ticks later row_idx=1 and blank is high for exactly 4 clk.
//  T3 frame: run 8 rows -> frame_strobe is a single pulse coincident with
//     row_idx 7->0; no pulse at any other row boundary.
//  T4 presc_load with presc_val=5 at prescaler count 7 -> the current period
//     still ends at 16; the next periods are 5 clk; presc_val=1 -> 2 clk.
//  T5 stdby_req=1 mid-row -> row finishes, state SLEEP, stdby_ok=1 the same cycle;
//     stop clk, drop stdby_req -> stdby_ok=0 immediately; restart clk -> 4-clk
//     blank, then the next row.
//  T6 en=0 at pwm_phase=9 -> blank=1, pwm_phase holds at 9; en=1 -> 4-clk blank,
//     then resume at phase 9 with row_idx unchanged.

Source files
------------

// File: rtl/led_scan_timer.sv
`timescale 1ns/1ps
// led_scan_timer: derives PWM tick/phase, row scan with blanking, frame strobe
// and the oscillator standby handshake from the OSCH output clock.
module led_scan_timer #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned PRESC_W   = 12,
  parameter int unsigned PRESC_DEF = 16,
  parameter int unsigned BLANK_CYC = 4,
  localparam int unsigned ROW_W    = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                presc_load,
  input  logic [PRESC_W-1:0]  presc_val,
  input  logic                stdby_req,
  output logic                stdby_ok,
  output logic [ROW_W-1:0]    row_idx,
  output logic [ROWS-1:0]     row_sel,
  output logic [PWM_BITS-1:0] pwm_phase,
  output logic                pwm_tick,
  output logic                blank,
  output logic                frame_strobe
);

  localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {BLANK, SCAN, SLEEP} state_t;

  state_t               state, state_n;
  logic [PRESC_W-1:0]   presc_cnt;
  logic [PRESC_W-1:0]   divisor;
  logic [PRESC_W-1:0]   pend_val;
  logic                 pend_valid;
  logic [BLANK_W-1:0]   blank_cnt;
  logic [PRESC_W-1:0]   load_clamped;
  logic                 term;
  logic                 row_end;
  logic                 blank_adv;

  // Divisors below 2 would make the prescaler degenerate; clamp them.
  assign load_clamped = (presc_val < PRESC_W'(2)) ? PRESC_W'(2) : presc_val;

  // Standby grant is combinational so it drops even while clk is stopped.
  assign stdby_ok = (state == SLEEP) && stdby_req;

  // One-hot row enable, only while actively scanning.
  always_comb begin
    row_sel = '0;
    if (state == SCAN) row_sel[row_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_n;
  end

  // Next-state logic, prescaler terminal count and row-end detection.
  always_comb begin
    // >= rather than == guards against a divisor shrunk while the count was held
    term      = (state == SCAN) && en && (presc_cnt >= divisor - PRESC_W'(1));
    row_end   = term && (pwm_phase == '1);
    state_n   = state;
    unique case (state)
      BLANK: begin
        if (!en)                          state_n = stdby_req ? SLEEP : BLANK;
        else if (blank_cnt == BLANK_LAST) state_n = SCAN;
      end
      SCAN: begin
        if (!en)          state_n = stdby_req ? SLEEP : BLANK;
        else if (row_end) state_n = stdby_req ? SLEEP : BLANK;
      end
      SLEEP: begin
        if (!stdby_req) state_n = BLANK;
      end
      default: state_n = BLANK;
    endcase
    blank_adv = (state == BLANK) && en && (state_n == BLANK);
  end

  // Counters, registered outputs and divisor management.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      pwm_phase    <= '0;
      row_idx      <= '0;
      blank_cnt    <= '0;
      pwm_tick     <= 1'b0;
      frame_strobe <= 1'b0;
      blank        <= 1'b1;
      divisor      <= PRESC_W'(PRESC_DEF);
      pend_val     <= PRESC_W'(PRESC_DEF);
      pend_valid   <= 1'b0;
    end else begin
      pwm_tick     <= term;
      frame_strobe <= row_end && (row_idx == ROW_LAST);
      blank        <= (state_n != SCAN);
      blank_cnt    <= blank_adv ? blank_cnt + BLANK_W'(1) : '0;

      if (term) begin
        presc_cnt <= '0;
        pwm_phase <= pwm_phase + PWM_BITS'(1);
        if (row_end) row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + ROW_W'(1);
      end else if (state == SCAN && en) begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end

      // Outside SCAN a load takes effect at once; a value still pending from an
      // interrupted row is applied on the first non-SCAN cycle.
      if (state != SCAN) begin
        if (presc_load) begin
          divisor    <= load_clamped;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          divisor    <= pend_val;
          pend_valid <= 1'b0;
        end
      end else begin
        if (term && pend_valid) begin
          divisor    <= pend_val;
          pend_valid <= 1'b0;
        end
        if (presc_load) begin
          pend_val   <= load_clamped;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_scan_timer.sv
`timescale 1ns/1ps
// Directed scoreboard bench for led_scan_timer.
module tb_led_scan_timer;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n;
  logic        en;
  logic        presc_load;
  logic [11:0] presc_val;
  logic        stdby_req;
  logic        stdby_ok;
  logic [2:0]  row_idx;
  logic [7:0]  row_sel;
  logic [3:0]  pwm_phase;
  logic        pwm_tick;
  logic        blank;
  logic        frame_strobe;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  led_scan_timer #(
    .ROWS(8), .PWM_BITS(4), .PRESC_W(12), .PRESC_DEF(16), .BLANK_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .presc_load(presc_load),
    .presc_val(presc_val), .stdby_req(stdby_req), .stdby_ok(stdby_ok),
    .row_idx(row_idx), .row_sel(row_sel), .pwm_phase(pwm_phase),
    .pwm_tick(pwm_tick), .blank(blank), .frame_strobe(frame_strobe)
  );

  // Gated clock so the oscillator stop can be modelled.
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %0h with no expected value", obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e.val)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int unsigned n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!pwm_tick && n < 2000);
  endtask

  task automatic wait_blank_low(output int unsigned n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (blank && n < 2000);
  endtask

  initial begin
    int unsigned n;
    int unsigned exp_row;
    int unsigned fs_count;
    int unsigned rows_done;

    rst_n = 1'b0; en = 1'b1; presc_load = 1'b0; presc_val = '0; stdby_req = 1'b0;

    // T1: reset state and release
    step(3);
    sb_push("rst_blank", 1);          sb_check(blank);
    sb_push("rst_row_sel", 0);        sb_check(row_sel);
    sb_push("rst_stdby_ok", 0);       sb_check(stdby_ok);
    sb_push("rst_row_idx", 0);        sb_check(row_idx);
    sb_push("rst_phase", 0);          sb_check(pwm_phase);
    sb_push("rst_tick_fs", 0);        sb_check({pwm_tick, frame_strobe});
    rst_n = 1'b1;
    step(3);
    sb_push("rel_row_sel_3clk", 0);   sb_check(row_sel);
    step(1);
    sb_push("rel_row_sel_4clk", 8'h01); sb_check(row_sel);
    sb_push("rel_blank_4clk", 0);     sb_check(blank);

    // T2: tick spacing and phase sequence over one row
    for (int unsigned i = 1; i <= 16; i++) begin
      wait_tick(n);
      sb_push("tick_spacing", 16);    sb_check(n);
      sb_push("tick_phase", i % 16);  sb_check(pwm_phase);
    end
    sb_push("rowend_row_idx", 1);     sb_check(row_idx);
    sb_push("rowend_blank", 1);       sb_check(blank);
    sb_push("rowend_fs", 0);          sb_check(frame_strobe);
    wait_blank_low(n);
    sb_push("blank_len", 4);          sb_check(n);
    sb_push("row1_sel", 8'h02);       sb_check(row_sel);

    // T3: frame strobe only on the 7->0 wrap
    exp_row = 1; fs_count = 0; rows_done = 0; n = 0;
    while (rows_done < 7 && n < 5000) begin
      step(1);
      n++;
      if (frame_strobe) fs_count++;
      if (pwm_tick && pwm_phase == 4'd0) begin
        rows_done++;
        exp_row = (exp_row + 1) % 8;
        sb_push("frame_row_idx", exp_row);          sb_check(row_idx);
        sb_push("frame_fs", (exp_row == 0) ? 1 : 0); sb_check(frame_strobe);
      end
    end
    sb_push("frame_rows_done", 7);    sb_check(rows_done);
    sb_push("frame_pulse_count", 1);  sb_check(fs_count);

    // T4: prescaler reload at count 7, clamp of 1 to 2
    wait_blank_low(n);
    sb_push("t4_blank_len", 4);       sb_check(n);
    wait_tick(n);
    sb_push("t4_first_tick", 16);     sb_check(n);
    step(7);
    presc_load = 1'b1; presc_val = 12'd5;
    step(1);
    presc_load = 1'b0;
    wait_tick(n);
    sb_push("t4_period_kept", 16 - 8); sb_check(n);
    sb_push("t4_phase2", 2);          sb_check(pwm_phase);
    for (int unsigned i = 0; i < 2; i++) begin
      wait_tick(n);
      sb_push("t4_period5", 5);       sb_check(n);
    end
    presc_load = 1'b1; presc_val = 12'd1;
    step(1);
    presc_load = 1'b0;
    wait_tick(n);
    sb_push("t4_period5_tail", 5 - 1); sb_check(n);
    for (int unsigned i = 0; i < 3; i++) begin
      wait_tick(n);
      sb_push("t4_period_clamped", 2); sb_check(n);
    end
    presc_load = 1'b1; presc_val = 12'd16;
    step(1);
    presc_load = 1'b0;
    wait_tick(n);
    sb_push("t4_period2_tail", 2 - 1); sb_check(n);
    sb_push("t4_phase9", 9);          sb_check(pwm_phase);

    // T6: disable mid-row at phase 9
    en = 1'b0;
    step(1);
    sb_push("dis_blank", 1);          sb_check(blank);
    sb_push("dis_tick", 0);           sb_check(pwm_tick);
    step(20);
    sb_push("dis_phase_hold", 9);     sb_check(pwm_phase);
    sb_push("dis_row_hold", 0);       sb_check(row_idx);
    sb_push("dis_row_sel", 0);        sb_check(row_sel);
    en = 1'b1;
    wait_blank_low(n);
    sb_push("en_blank_len", 4);       sb_check(n);
    sb_push("en_phase", 9);           sb_check(pwm_phase);
    sb_push("en_row_sel", 8'h01);     sb_check(row_sel);
    wait_tick(n);
    sb_push("en_tick_spacing", 16);   sb_check(n);
    sb_push("en_phase10", 10);        sb_check(pwm_phase);

    // T5: standby requested mid-row, honoured at row end
    stdby_req = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(pwm_tick && pwm_phase == 4'd0) && n < 500);
    sb_push("sby_row_finish", 6 * 16); sb_check(n);
    sb_push("sby_ok", 1);             sb_check(stdby_ok);
    sb_push("sby_blank", 1);          sb_check(blank);
    sb_push("sby_row_idx", 1);        sb_check(row_idx);
    @(negedge clk);
    clk_run = 1'b0;
    #20;
    sb_push("sby_ok_stopped", 1);     sb_check(stdby_ok);
    stdby_req = 1'b0;
    #1;
    sb_push("sby_release", 0);        sb_check(stdby_ok);
    #30;
    clk_run = 1'b1;
    step(1);
    sb_push("wake_blank", 1);         sb_check(blank);
    wait_blank_low(n);
    sb_push("wake_blank_len", 4);     sb_check(n);
    sb_push("wake_row_sel", 8'h02);   sb_check(row_sel);
    sb_push("wake_phase", 0);         sb_check(pwm_phase);

    // Asynchronous reset mid-row
    step(30);
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("arst_blank", 1);         sb_check(blank);
    sb_push("arst_row_sel", 0);       sb_check(row_sel);
    sb_push("arst_row_idx", 0);       sb_check(row_idx);
    sb_push("arst_phase", 0);         sb_check(pwm_phase);
    step(2);
    rst_n = 1'b1;
    step(4);
    sb_push("arst_rel_row_sel", 8'h01); sb_check(row_sel);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
